// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared encodings for the EX-stage divider requester
// State codes and divider handshake levels used by div_ctrl and its bench.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivCtrlIdle = 2'b00,
    DivCtrlBusy = 2'b01,
    DivCtrlDone = 2'b10
  } div_ctrl_state_e;

  // Divider handshake levels: start held high runs it, dropping start frees it.
  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic DivResultReady = 1'b1;

  localparam int DivTimeoutDefault = 48;
  localparam int DivCntWDefault    = 6;

endpackage

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EX request, divider handshake and HI/LO write bundle
// slave is the div_ctrl side; master is the pipeline/divider side.
interface div_ctrl_if;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        flush_i;
  logic        ex_stall_i;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        stallreq_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        err_o;

  modport slave (
    input  div_req_i, div_signed_i, rs_data_i, rt_data_i, flush_i, ex_stall_i,
           div_ready_i, div_result_i,
    output div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
           stallreq_o, whilo_o, hi_o, lo_o, err_o
  );

  modport master (
    output div_req_i, div_signed_i, rs_data_i, rt_data_i, flush_i, ex_stall_i,
           div_ready_i, div_result_i,
    input  div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
           stallreq_o, whilo_o, hi_o, lo_o, err_o
  );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - launches the iterative divider and stalls EX until it answers
// Holds the 64-bit result for the HI/LO write; aborts on flush or on timeout.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DivTimeoutDefault,
  parameter int CNT_W          = DivCntWDefault
) (
  input logic      clk,
  input logic      rst,
  div_ctrl_if.slave bus
);

  div_ctrl_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_d;
  logic             annul_q;
  logic             err_q;
  logic             signed_q;
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  assign cnt_d     = cnt_q + 1'b1;
  assign timeout_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivCtrlIdle;
      cnt_q    <= '0;
      annul_q  <= 1'b0;
      err_q    <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      annul_q <= 1'b0;
      case (state_q)
        DivCtrlIdle: begin
          if (bus.div_req_i && !bus.flush_i) begin
            op1_q    <= bus.rs_data_i;
            op2_q    <= bus.rt_data_i;
            signed_q <= bus.div_signed_i;
            cnt_q    <= '0;
            state_q  <= DivCtrlBusy;
          end
        end
        DivCtrlBusy: begin
          cnt_q <= cnt_d;
          if (bus.flush_i) begin
            annul_q <= 1'b1;
            state_q <= DivCtrlIdle;
          end else if (bus.div_ready_i == DivResultReady) begin
            hi_q    <= bus.div_result_i[63:32];
            lo_q    <= bus.div_result_i[31:0];
            state_q <= DivCtrlDone;
          end else if (timeout_d) begin
            err_q   <= 1'b1;
            state_q <= DivCtrlIdle;
          end
        end
        DivCtrlDone: begin
          // A held request here is the same instruction still parked in EX.
          if (bus.flush_i || !bus.ex_stall_i) begin
            state_q <= DivCtrlIdle;
          end
        end
        default: state_q <= DivCtrlIdle;
      endcase
    end
  end

  assign bus.div_start_o   = (state_q == DivCtrlBusy) ? DivStart : DivStop;
  assign bus.div_annul_o   = annul_q;
  assign bus.div_signed_o  = signed_q;
  assign bus.div_opdata1_o = op1_q;
  assign bus.div_opdata2_o = op2_q;
  assign bus.stallreq_o    = ((state_q == DivCtrlIdle) && bus.div_req_i && !bus.flush_i)
                           || (state_q == DivCtrlBusy);
  assign bus.whilo_o       = (state_q == DivCtrlDone) && !bus.flush_i;
  assign bus.hi_o          = (state_q == DivCtrlDone) ? hi_q : 32'h0;
  assign bus.lo_o          = (state_q == DivCtrlDone) ? lo_q : 32'h0;
  assign bus.err_o         = err_q;

endmodule
